bitmap_store: RTL

Parametrised playfield store for the Tetris datapath: owns the board bitmap as COLS column registers of ROWS bits each. Provides cell/column writes, registered cell/row/column reads, and a line-clear sequencer. The sequencer scans for full rows and collapses the board downward. It sits between the game-logic CPU peripherals and the display scan-out, replacing externally held column registers.

---
 rtl/bitmap_store.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bitmap_store.sv
// rtl/bitmap_store.sv - Tetris playfield bitmap: cell/column writes, registered reads, line clear
// The line-clear sequencer is built only when BITMAP_STORE_LINE_CLEAR_EN is defined.
module bitmap_store #(
   parameter int COLS = 16,
   parameter int ROWS = 32,
   parameter int XW   = $clog2(COLS),
   parameter int YW   = $clog2(ROWS),
   parameter int LW   = $clog2(ROWS + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic            wr_mode,
   input  logic [XW-1:0]   wr_x,
   input  logic [YW-1:0]   wr_y,
   input  logic            wr_bit,
   input  logic [ROWS-1:0] wr_col,
   input  logic [1:0]      rd_mode,
   input  logic [XW-1:0]   rd_x,
   input  logic [YW-1:0]   rd_y,
   output logic [ROWS-1:0] rd_data,
   input  logic            clr_start,
   output logic            busy,
   output logic            clr_done,
   output logic [LW-1:0]   lines_cleared
);

   logic [ROWS-1:0] col_q [COLS];
   logic [ROWS-1:0] col_d [COLS];
   logic [ROWS-1:0] rd_data_q, rd_data_d;
   logic            wr_ok;

   // Row 0 is the top of the board and lives in the MSB of each column image.
   function automatic logic [YW-1:0] row_bit(input logic [YW-1:0] y);
      return YW'(ROWS - 1) - y;
   endfunction

   always_comb begin
      rd_data_d = '0;
      case (rd_mode)
         2'd0: if (int'(rd_x) < COLS && int'(rd_y) < ROWS)
                  rd_data_d[0] = col_q[rd_x][row_bit(rd_y)];
         2'd1: if (int'(rd_y) < ROWS)
                  for (int k = 0; k < COLS; k++) rd_data_d[k] = col_q[k][row_bit(rd_y)];
         2'd2: if (int'(rd_x) < COLS) rd_data_d = col_q[rd_x];
         default: rd_data_d = '0;
      endcase
   end

`ifdef BITMAP_STORE_LINE_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [YW-1:0]   r_q, r_d;
   logic [LW-1:0]   lines_q, lines_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            row_full;
   logic [ROWS-1:0] shift_mask;

   always_comb begin
      row_full = 1'b1;
      for (int x = 0; x < COLS; x++) row_full = row_full & col_q[x][row_bit(r_q)];
      // Everything at or above the cleared row drops by one.
      shift_mask = {ROWS{1'b1}} << row_bit(r_q);
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      lines_d = lines_q;
      case (state_q)
         S_IDLE: if (clr_start) begin
            state_d = S_SCAN;
            r_d     = YW'(ROWS - 1);
            lines_d = '0;
         end
         S_SCAN: begin
            if (row_full)        state_d = S_SHIFT;
            else if (r_q != '0)  r_d = r_q - 1'b1;
            else                 state_d = S_DONE;
         end
         S_SHIFT: begin
            state_d = S_SCAN;
            lines_d = lines_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign wr_ok         = wr_en && (state_q == S_IDLE);
   assign busy          = busy_q;
   assign clr_done      = done_q;
   assign lines_cleared = lines_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         lines_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         lines_q <= lines_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
`else
   logic unused_clr_start;

   assign unused_clr_start = clr_start;
   assign wr_ok            = wr_en;
   assign busy             = 1'b0;
   assign clr_done         = 1'b0;
   assign lines_cleared    = '0;
`endif

   always_comb begin
      for (int x = 0; x < COLS; x++) col_d[x] = col_q[x];
      if (wr_ok && int'(wr_x) < COLS) begin
         if (wr_mode)                   col_d[wr_x] = wr_col;
         else if (int'(wr_y) < ROWS)    col_d[wr_x][row_bit(wr_y)] = wr_bit;
      end
`ifdef BITMAP_STORE_LINE_CLEAR_EN
      if (state_q == S_SHIFT)
         for (int x = 0; x < COLS; x++)
            col_d[x] = (col_q[x] & ~shift_mask) | ((col_q[x] >> 1) & shift_mask);
`endif
   end

   assign rd_data = rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int x = 0; x < COLS; x++) col_q[x] <= '0;
         rd_data_q <= '0;
      end else begin
         for (int x = 0; x < COLS; x++) col_q[x] <= col_d[x];
         rd_data_q <= rd_data_d;
      end
   end

endmodule
